alu_seq: RTL

Parametrised, handshaked successor to the combinational 8-bit ALU. It registers every result together with status flags (carry, zero, negative, overflow). It adds two multi-cycle operations: iterative left shift and shift-add multiply. The block sits between an operand source and a result consumer, and uses a valid/ready handshake on both sides.

---
 rtl/alu_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential, handshaked ALU with registered result and status flags.
// Single-cycle logic/arith ops, plus iterative SHL and shift-add MUL that run in EXEC.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  state_e             state_q, state_d;
  opcode_e            op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     subDiff;
  logic [2*WIDTH-1:0] accNext;
  logic               loadRes;
  logic [WIDTH-1:0]   newRes;
  logic               newCarry;
  logic               newOvf;

  // Extended-width sum/difference expose carry and borrow in the top bit.
  assign addSum  = {1'b0, a} + {1'b0, b};
  assign subDiff = {1'b0, a} - {1'b0, b};
  assign accNext = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    loadRes  = 1'b0;
    newRes   = '0;
    newCarry = 1'b0;
    newOvf   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = opcode_e'(op);
          state_d = DONE;
          case (opcode_e'(op))
            OP_ADD: begin
              loadRes  = 1'b1;
              newRes   = addSum[WIDTH-1:0];
              newCarry = addSum[WIDTH];
              newOvf   = (a[WIDTH-1] == b[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              loadRes  = 1'b1;
              newRes   = subDiff[WIDTH-1:0];
              newCarry = subDiff[WIDTH];
              newOvf   = (a[WIDTH-1] != b[WIDTH-1]) && (subDiff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin
              loadRes = 1'b1;
              newRes  = a & b;
            end
            OP_OR: begin
              loadRes = 1'b1;
              newRes  = a | b;
            end
            OP_XOR: begin
              loadRes = 1'b1;
              newRes  = a ^ b;
            end
            OP_NOT: begin
              loadRes = 1'b1;
              newRes  = ~a;
            end
            OP_SHL: begin
              if (b[SHW-1:0] == '0) begin
                loadRes = 1'b1;
                newRes  = a;
              end else begin
                work_d  = a;
                cnt_d   = {1'b0, b[SHW-1:0]};
                state_d = EXEC;
              end
            end
            default: begin
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              acc_d    = '0;
              cnt_d    = CW'(WIDTH);
              state_d  = EXEC;
            end
          endcase
        end
      end

      EXEC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q == OP_SHL) begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          if (cnt_q == CNT_ONE) begin
            loadRes  = 1'b1;
            newRes   = {work_q[WIDTH-2:0], 1'b0};
            newCarry = work_q[WIDTH-1];
          end
        end else begin
          acc_d    = accNext;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          if (cnt_q == CNT_ONE) begin
            loadRes  = 1'b1;
            newRes   = accNext[WIDTH-1:0];
            newCarry = |accNext[2*WIDTH-1:WIDTH];
          end
        end
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Flags are only rewritten when a new result lands, so they hold through DONE.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    if (loadRes) begin
      result_d = newRes;
      carry_d  = newCarry;
      zero_d   = (newRes == '0);
      neg_d    = newRes[WIDTH-1];
      ovf_d    = newOvf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      work_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  // in_ready is forced low while reset is held so nothing is accepted during reset.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == EXEC);
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule
